io_bus_arbiter: RTL and testbench

- Shares the single I/O register port of the PET I/O block (PIAs, VIA, CRTC at 0xE8xx) between two requesters: the 6502 CPU and a host-side requester (HPS debugger / IEEE-488 drive-emulation helper).
- The CPU always wins. Host accesses go into idle clock cycles between CPU enable pulses, so the CPU never stalls and never sees corrupted read data.
- Sits between the CPU/host buses and the I/O block's data_in/addr/cs/we/strobe/data_out interface.

---
 rtl/io_bus_arbiter_if.sv | 46 ++++
 rtl/io_bus_arbiter.sv | 116 +++++++++++
 tb/tb_io_bus_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
// Bundles the CPU, host and I/O-block signals of the I/O register port arbiter.
// slave: arbiter view; master: the surrounding CPU/host/I/O environment.
interface io_bus_arbiter_if;
  logic       cpu_ce;
  logic       cpu_cs;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;

  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;

  logic       io_stb;
  logic       io_cs;
  logic       io_we;
  logic [7:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;

  logic       collision;

  modport slave (
    input  cpu_ce, cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output io_stb, io_cs, io_we, io_addr, io_wdata,
    input  io_rdata,
    output collision
  );

  modport master (
    output cpu_ce, cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  io_stb, io_cs, io_we, io_addr, io_wdata,
    output io_rdata,
    input  collision
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Shares the PET I/O register port between the 6502 (always wins) and a host requester
// whose accesses are slotted into the idle clocks between CPU enable pulses.
module io_bus_arbiter #(
  parameter int unsigned CePeriod = 32,
  parameter int unsigned MinGap   = 2,
  parameter int unsigned RdLat    = 1
) (
  input logic             clk,
  input logic             reset_n,
  io_bus_arbiter_if.slave bus
);

  localparam logic [7:0] WinLo    = 8'(MinGap);
  localparam logic [7:0] WinHi    = 8'(CePeriod - 2 - RdLat - MinGap);
  localparam logic [7:0] WaitLast = 8'(RdLat - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           state_q;
  logic [7:0]       ph_q, ph_d;
  logic [7:0]       wait_q;
  logic [RdLat-1:0] rd_pipe_q;
  logic [7:0]       cpu_rdata_q;
  logic [7:0]       host_rdata_q;
  logic             host_ack_q;
  logic             collision_q;

  logic host_win;
  logic host_sel;
  logic rd_start;

  // Saturating phase; 8'hFF out of reset keeps the host out until the first cpu_ce.
  always_comb begin
    if (bus.cpu_ce) begin
      ph_d = 8'h00;
    end else if (ph_q == 8'hFF) begin
      ph_d = ph_q;
    end else begin
      ph_d = ph_q + 8'd1;
    end
  end

  assign host_win = !bus.cpu_ce && (ph_q >= WinLo) && (ph_q <= WinHi) &&
                    (state_q == StIdle) && bus.host_req;
  assign rd_start = bus.cpu_ce && bus.cpu_cs && !bus.cpu_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      ph_q         <= 8'hFF;
      wait_q       <= 8'h00;
      rd_pipe_q    <= '0;
      cpu_rdata_q  <= 8'h00;
      host_rdata_q <= 8'h00;
      host_ack_q   <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      host_ack_q <= 1'b0;

      rd_pipe_q[0] <= rd_start;
      for (int i = 1; i < int'(RdLat); i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
      if (rd_pipe_q[RdLat-1]) begin
        cpu_rdata_q <= bus.io_rdata;
      end

      if (bus.cpu_ce && ((state_q == StIssue) || (state_q == StWait))) begin
        collision_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (host_win) begin
            state_q <= StIssue;
          end
        end
        StIssue: begin
          wait_q  <= 8'h00;
          state_q <= StWait;
        end
        StWait: begin
          if (wait_q == WaitLast) begin
            host_rdata_q <= bus.io_rdata;
            host_ack_q   <= 1'b1;
            state_q      <= StDone;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // A cpu_ce always takes the port, even in the middle of a host cycle.
  assign host_sel = !bus.cpu_ce && ((state_q == StIssue) || (state_q == StWait));

  assign bus.io_stb   = bus.cpu_ce ? bus.cpu_cs : (state_q == StIssue);
  assign bus.io_cs    = host_sel ? 1'b1           : bus.cpu_cs;
  assign bus.io_we    = host_sel ? bus.host_we    : bus.cpu_we;
  assign bus.io_addr  = host_sel ? bus.host_addr  : bus.cpu_addr;
  assign bus.io_wdata = host_sel ? bus.host_wdata : bus.cpu_wdata;

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.collision  = collision_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: reset, table-driven CPU vectors, directed host/collision
// sequences, and a randomized run against a cycle-count reference model.
module tb_io_bus_arbiter;

  localparam int CE_PERIOD = 32;
  localparam int MIN_GAP   = 2;
  localparam int RD_LAT    = 1;
  localparam int WIN_HI    = CE_PERIOD - 2 - RD_LAT - MIN_GAP;

  logic clk;
  logic reset_n;

  io_bus_arbiter_if bus ();

  io_bus_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Simple I/O block: memory with a one-clock read latency.
  logic       env_en;
  logic       env_clr;
  logic [7:0] env_mem [256];
  logic [7:0] env_rd;
  logic [7:0] io_rd_drv;

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i) ^ 8'h5A;
      env_rd <= 8'h00;
    end else if (env_en && bus.io_stb && bus.io_cs) begin
      if (bus.io_we) env_mem[bus.io_addr] <= bus.io_wdata;
      else           env_rd <= env_mem[bus.io_addr];
    end
  end

  assign bus.io_rdata = env_en ? env_rd : io_rd_drv;

  typedef struct {
    logic       ce;
    logic       cs;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    logic       exp_stb;
    logic [7:0] exp_cpu;
  } vec_t;

  vec_t vecs [13];

  // Reference model state for the randomized run.
  logic [7:0] ref_mem [256];
  int         last_ce, next_ce, issue_at, ack_at_m, cpu_vis_at, ph;
  logic [7:0] exp_cpu, cpu_pend, exp_hrd;
  logic       h_is_rd, idle_m, exp_issue, exp_ack, ce_now, saw_ack;
  logic       e_stb, e_we;
  logic [7:0] e_addr, e_wd;
  int         stb_k, ack_k, acks, stbs;
  logic [7:0] hrd_at_ack, exp_late;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic cpu_idle();
    bus.cpu_ce    = 1'b0;
    bus.cpu_cs    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'h00;
  endtask

  task automatic host_set(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    env_clr = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    env_clr = 1'b0;
  endtask

  // One CPU enable with chip-select low, used to open a host window.
  task automatic ce_blank();
    cpu_idle();
    bus.cpu_ce = 1'b1;
    smp();
    tick();
    bus.cpu_ce = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    env_en        = 1'b0;
    env_clr       = 1'b1;
    io_rd_drv     = 8'h00;
    cpu_idle();
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 8'h00;
    bus.host_wdata = 8'h00;

    // Reset values.
    repeat (3) @(posedge clk);
    smp();
    chk("rst_host_ack", bus.host_ack, 0);
    chk("rst_io_stb", bus.io_stb, 0);
    chk("rst_collision", bus.collision, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    chk("rst_host_rdata", bus.host_rdata, 8'h00);
    tick();
    reset_n = 1'b1;
    env_clr = 1'b0;

    // No cpu_ce yet: host must stay locked out.
    host_set(1'b1, 8'h33, 8'h44);
    stbs = 0;
    acks = 0;
    for (int k = 0; k < 100; k++) begin
      smp();
      if (bus.io_stb) stbs++;
      if (bus.host_ack) acks++;
      tick();
    end
    chk("prece_stb_count", stbs, 0);
    chk("prece_ack_count", acks, 0);
    bus.host_req = 1'b0;

    // CPU-only vectors, io_rdata driven directly.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h3A, 8'h00, 8'h77, 1'b0, 8'hA5};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h34, 8'h9C, 8'h11, 1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h22, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h56, 8'h00, 8'h00, 1'b0, 8'hA5};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h33, 1'b0, 8'hA5};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00, 1'b1, 8'hA5};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h0B, 8'hE1, 8'h55, 1'b0, 8'hA5};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h55};
    for (int i = 0; i < 13; i++) begin
      bus.cpu_ce    = vecs[i].ce;
      bus.cpu_cs    = vecs[i].cs;
      bus.cpu_we    = vecs[i].we;
      bus.cpu_addr  = vecs[i].addr;
      bus.cpu_wdata = vecs[i].wdata;
      io_rd_drv     = vecs[i].rd;
      smp();
      chk($sformatf("vec%0d_stb", i), bus.io_stb, vecs[i].exp_stb);
      chk($sformatf("vec%0d_addr", i), bus.io_addr, vecs[i].addr);
      chk($sformatf("vec%0d_we", i), bus.io_we, vecs[i].we);
      chk($sformatf("vec%0d_wdata", i), bus.io_wdata, vecs[i].wdata);
      chk($sformatf("vec%0d_cpu_rdata", i), bus.cpu_rdata, vecs[i].exp_cpu);
      tick();
    end
    cpu_idle();
    io_rd_drv = 8'h00;

    // Host write early in the period.
    ce_blank();
    host_set(1'b1, 8'h22, 8'h3C);
    stb_k = -1;
    ack_k = -1;
    acks  = 0;
    for (int k = 1; k <= 10; k++) begin
      smp();
      if (bus.io_stb && stb_k < 0) begin
        stb_k = k;
        chk("hw_io_addr", bus.io_addr, 8'h22);
        chk("hw_io_wdata", bus.io_wdata, 8'h3C);
        chk("hw_io_we", bus.io_we, 1);
        chk("hw_io_cs", bus.io_cs, 1);
      end
      saw_ack = bus.host_ack;
      if (saw_ack) begin
        acks++;
        if (ack_k < 0) ack_k = k;
      end
      tick();
      if (saw_ack) bus.host_req = 1'b0;
    end
    chk("hw_stb_cycle", stb_k, 4);
    chk("hw_ack_cycle", ack_k, 6);
    chk("hw_ack_count", acks, 1);

    // Host read requested too late in the period: deferred to the next one.
    ce_blank();
    stb_k      = -1;
    ack_k      = -1;
    hrd_at_ack = 8'h00;
    for (int k = 1; k <= 45; k++) begin
      io_rd_drv  = 8'(k * 7 + 3);
      bus.cpu_ce = (k == 32);
      if (k == 29) host_set(1'b0, 8'h40, 8'h00);
      smp();
      if (bus.io_stb && stb_k < 0) stb_k = k;
      saw_ack = bus.host_ack;
      if (saw_ack && ack_k < 0) begin
        ack_k      = k;
        hrd_at_ack = bus.host_rdata;
      end
      tick();
      if (saw_ack) bus.host_req = 1'b0;
    end
    bus.cpu_ce = 1'b0;
    exp_late   = 8'(37 * 7 + 3);
    chk("late_stb_cycle", stb_k, 36);
    chk("late_ack_cycle", ack_k, 38);
    chk("late_host_rdata", hrd_at_ack, exp_late);

    // Isolation: CPU reads 55, host reads AA in the same period.
    env_en        = 1'b1;
    bus.cpu_ce    = 1'b1;
    bus.cpu_cs    = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 8'h0F;
    smp();
    tick();
    cpu_idle();
    host_set(1'b0, 8'hF0, 8'h00);
    acks = 0;
    for (int k = 1; k <= 10; k++) begin
      smp();
      saw_ack = bus.host_ack;
      if (saw_ack) acks++;
      tick();
      if (saw_ack) bus.host_req = 1'b0;
    end
    smp();
    chk("iso_cpu_rdata", bus.cpu_rdata, 8'h55);
    chk("iso_host_rdata", bus.host_rdata, 8'hAA);
    chk("iso_ack_count", acks, 1);
    tick();

    // Randomized run against the reference model.
    pulse_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    last_ce    = -1;
    next_ce    = 3;
    issue_at   = -1;
    ack_at_m   = -1;
    cpu_vis_at = -1;
    exp_cpu    = 8'h00;
    cpu_pend   = 8'h00;
    exp_hrd    = 8'h00;
    h_is_rd    = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ce_now        = (c == next_ce);
      bus.cpu_ce    = ce_now;
      bus.cpu_cs    = ($urandom_range(0, 3) != 0);
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = 8'($urandom_range(0, 15));
      bus.cpu_wdata = 8'($urandom);
      if (!bus.host_req && $urandom_range(0, 5) == 0) begin
        host_set(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      end
      smp();

      ph        = c - last_ce - 1;
      idle_m    = (issue_at < 0) || (c > ack_at_m);
      exp_issue = (issue_at == c);
      exp_ack   = (issue_at >= 0) && (c == ack_at_m);
      if (idle_m && bus.host_req && !ce_now && last_ce >= 0 && ph >= MIN_GAP && ph <= WIN_HI)
      begin
        issue_at = c + 1;
        ack_at_m = c + 2 + RD_LAT;
      end

      if (ce_now) begin
        e_stb  = bus.cpu_cs;
        e_we   = bus.cpu_we;
        e_addr = bus.cpu_addr;
        e_wd   = bus.cpu_wdata;
      end else if (exp_issue) begin
        e_stb  = 1'b1;
        e_we   = bus.host_we;
        e_addr = bus.host_addr;
        e_wd   = bus.host_wdata;
      end else begin
        e_stb  = 1'b0;
        e_we   = 1'b0;
        e_addr = 8'h00;
        e_wd   = 8'h00;
      end
      chk("rnd_io_stb", bus.io_stb, e_stb);
      if (e_stb) begin
        chk("rnd_io_cs", bus.io_cs, 1);
        chk("rnd_io_addr", bus.io_addr, e_addr);
        chk("rnd_io_we", bus.io_we, e_we);
        if (e_we) chk("rnd_io_wdata", bus.io_wdata, e_wd);
      end

      if (ce_now && bus.cpu_cs) begin
        if (bus.cpu_we) begin
          ref_mem[bus.cpu_addr] = bus.cpu_wdata;
        end else begin
          cpu_pend   = ref_mem[bus.cpu_addr];
          cpu_vis_at = c + 1 + RD_LAT;
        end
      end
      if (exp_issue) begin
        h_is_rd = !bus.host_we;
        if (bus.host_we) ref_mem[bus.host_addr] = bus.host_wdata;
        else             exp_hrd = ref_mem[bus.host_addr];
      end
      if (c == cpu_vis_at) exp_cpu = cpu_pend;

      chk("rnd_cpu_rdata", bus.cpu_rdata, exp_cpu);
      chk("rnd_host_ack", bus.host_ack, exp_ack);
      if (exp_ack && h_is_rd) chk("rnd_host_rdata", bus.host_rdata, exp_hrd);
      chk("rnd_collision", bus.collision, 0);

      if (ce_now) begin
        last_ce = c;
        next_ce = c + $urandom_range(CE_PERIOD, CE_PERIOD + 8);
      end
      saw_ack = bus.host_ack;
      tick();
      if (saw_ack) bus.host_req = 1'b0;
    end
    cpu_idle();
    bus.host_req = 1'b0;

    // Collision: CPU cycle forced into the host WAIT clock.
    pulse_reset();
    ce_blank();
    host_set(1'b0, 8'h0F, 8'h00);
    ack_k = -1;
    acks  = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) begin
        bus.cpu_ce    = 1'b1;
        bus.cpu_cs    = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 8'h77;
        bus.cpu_wdata = 8'h99;
      end else begin
        cpu_idle();
      end
      smp();
      if (k == 4) chk("col_pre_flag", bus.collision, 0);
      if (k == 5) begin
        chk("col_io_stb", bus.io_stb, 1);
        chk("col_io_addr", bus.io_addr, 8'h77);
        chk("col_io_we", bus.io_we, 1);
        chk("col_io_wdata", bus.io_wdata, 8'h99);
      end
      saw_ack = bus.host_ack;
      if (saw_ack) begin
        acks++;
        if (ack_k < 0) ack_k = k;
      end
      tick();
      if (saw_ack) bus.host_req = 1'b0;
    end
    smp();
    chk("col_sticky", bus.collision, 1);
    chk("col_ack_cycle", ack_k, 6);
    chk("col_ack_count", acks, 1);
    tick();

    // Async reset in the ISSUE clock aborts the host cycle without an ack.
    ce_blank();
    host_set(1'b1, 8'h10, 8'h20);
    for (int k = 1; k <= 3; k++) begin
      smp();
      tick();
    end
    chk("rstmid_issue_stb", bus.io_stb, 1);
    #1;
    reset_n = 1'b0;
    smp();
    chk("rstmid_io_stb", bus.io_stb, 0);
    chk("rstmid_host_ack", bus.host_ack, 0);
    chk("rstmid_collision", bus.collision, 0);
    chk("rstmid_cpu_rdata", bus.cpu_rdata, 8'h00);
    bus.host_req = 1'b0;
    tick();
    reset_n = 1'b1;
    acks = 0;
    stbs = 0;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (bus.host_ack) acks++;
      if (bus.io_stb) stbs++;
      tick();
    end
    chk("rstmid_ack_count", acks, 0);
    chk("rstmid_stb_count", stbs, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
